// File: rtl/m_uxa_ps2_rxq_pkg.sv
// ============================================================================
// Module      : uxa_ps2_pkg
// Description : Shared constants for the UXA PS/2 receive queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uxa_ps2_pkg;

    localparam int c_DEF_DATA_W     = 8;
    localparam int c_DEF_DEPTH_LOG2 = 4;

    // One-hot receive sequencer states
    localparam logic [3:0] S_IDLE  = 4'b0001;
    localparam logic [3:0] S_WRITE = 4'b0010;
    localparam logic [3:0] S_CLEAR = 4'b0100;
    localparam logic [3:0] S_HOLD  = 4'b1000;

endpackage

`default_nettype wire

// File: rtl/m_uxa_ps2_rxq_if.sv
// ============================================================================
// Module      : m_uxa_ps2_rxq_if
// Description : Bus-side pop/status interface of the PS/2 receive queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface m_uxa_ps2_rxq_if
    import uxa_ps2_pkg::*;
#(
    parameter int DATA_W     = c_DEF_DATA_W,
    parameter int DEPTH_LOG2 = c_DEF_DEPTH_LOG2
);
    logic                  rd_i;
    logic                  ovr_clr_i;
    logic [DATA_W-1:0]     data_o;
    logic                  empty_o;
    logic                  full_o;
    logic [DEPTH_LOG2:0]   count_o;
    logic                  overrun_o;

    modport master (
        output rd_i, ovr_clr_i,
        input  data_o, empty_o, full_o, count_o, overrun_o
    );

    modport slave (
        input  rd_i, ovr_clr_i,
        output data_o, empty_o, full_o, count_o, overrun_o
    );
endinterface

`default_nettype wire

// File: rtl/m_uxa_ps2_rxq_sync.sv
// ============================================================================
// Module      : m_uxa_ps2_sync
// Description : Multi-flop level synchroniser with rising-edge detect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module m_uxa_ps2_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_async,
    output logic      o_sync,
    output logic      o_rise
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_edge <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_edge;
endmodule

`default_nettype wire

// File: rtl/m_uxa_ps2_rxq.sv
// ============================================================================
// Module      : m_uxa_ps2_rxq
// Description : PS/2 receive queue: frame capture FSM plus FWFT FIFO.
//               Optional build macro: UXA_PS2_RXQ_OVERWRITE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module m_uxa_ps2_rxq
    import uxa_ps2_pkg::*;
#(
    parameter int DATA_W      = c_DEF_DATA_W,
    parameter int DEPTH_LOG2  = c_DEF_DEPTH_LOG2,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic              sys_clk_i,
    input  wire logic              sys_reset_i,
    input  wire logic              frame_i,
    input  wire logic [DATA_W-1:0] data_i,
    output logic                   deser_reset_o,
    m_uxa_ps2_rxq_if.slave         bus
);
    localparam int                  c_DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL_CNT = (DEPTH_LOG2+1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2:0] c_CNT_ONE  = (DEPTH_LOG2+1)'(1);

    logic [3:0]            r_state;
    logic [3:0]            w_state_nxt;
    logic [DATA_W-1:0]     r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wp;
    logic [DEPTH_LOG2-1:0] r_rp;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_ovr;

    logic w_sync;
    logic w_rise;
    logic w_full;
    logic w_empty;
    logic w_slot;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_ovwr;

    m_uxa_ps2_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_frame_sync (
        .clk     (sys_clk_i),
        .rst     (sys_reset_i),
        .i_async (frame_i),
        .o_sync  (w_sync),
        .o_rise  (w_rise)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_rise) w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = S_CLEAR;
            S_CLEAR: w_state_nxt = S_HOLD;
            // A lingering frame level must drop before another capture
            S_HOLD:  if (!w_sync) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge sys_reset_i) begin
        if (sys_reset_i) r_state <= S_IDLE;
        else             r_state <= w_state_nxt;
    end

    assign w_full  = (r_count == c_FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_slot  = (r_state == S_WRITE);
    assign w_pop   = bus.rd_i & ~w_empty;
    // A concurrent pop frees a slot, so a write while full still lands
    assign w_push  = w_slot & (~w_full | w_pop);
    assign w_drop  = w_slot & w_full & ~w_pop;

`ifdef UXA_PS2_RXQ_OVERWRITE_EN
    assign w_ovwr = w_drop;
`else
    assign w_ovwr = 1'b0;
`endif

    always_ff @(posedge sys_clk_i) begin
        if (w_push | w_ovwr) r_mem[r_wp] <= data_i;
    end

    always_ff @(posedge sys_clk_i or posedge sys_reset_i) begin
        if (sys_reset_i) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_push | w_ovwr) r_wp <= r_wp + 1'b1;
            if (w_pop  | w_ovwr) r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop)             r_ovr <= 1'b1;
            else if (bus.ovr_clr_i) r_ovr <= 1'b0;
        end
    end

    assign deser_reset_o = (r_state == S_CLEAR);
    assign bus.data_o    = r_mem[r_rp];
    assign bus.empty_o   = w_empty;
    assign bus.full_o    = w_full;
    assign bus.count_o   = r_count;
    assign bus.overrun_o = r_ovr;
endmodule

`default_nettype wire

// File: doc/m_uxa_ps2_rxq.md
Name: m_uxa_ps2_rxq

Overview:
Receive queue for the UXA PS/2 port. It synchronises the deserializer's frame strobe and captures each completed byte into an internal parametrised FIFO. It then pulses the deserializer reset and presents bytes first-word-fall-through to the bus side. It adds full/empty/count status, a sticky overrun flag and a configurable synchroniser depth.

Parameters:
DATA_W, 8, width of a received frame word.
DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 16 entries).
SYNC_STAGES, 2, flip-flops in the frame_i synchroniser (legal 2..4).

Ports:
sys_clk_i  in  1  system clock; all logic on rising edge.
sys_reset_i  in  1  asynchronous, active-high reset.
frame_i  in  1  deserializer "byte complete" level; asynchronous to sys_clk_i.
data_i  in  DATA_W  deserializer shift register; stable while frame_i is high.
deser_reset_o  out  1  one-cycle pulse clearing the deserializer.
rd_i  in  1  pop request from bus side.
data_o  out  DATA_W  head of FIFO (FWFT); undefined when empty.
empty_o  out  1  FIFO holds 0 entries.
full_o  out  1  FIFO holds DEPTH entries.
count_o  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
overrun_o  out  1  sticky: a frame arrived while full.
ovr_clr_i  in  1  clears overrun_o.

Behaviour:
- Reset (async assert, sync release): state IDLE, wr/rd pointers 0, count_o 0, empty_o 1, full_o 0, overrun_o 0, deser_reset_o 0, synchroniser and edge register 0.
- Synchroniser: frame_i passes through SYNC_STAGES flops, then one edge register. rise = sync_out & ~edge_reg.
- FSM, one-hot, outputs decoded from state register:
  - IDLE: on rise, go to WRITE.
  - WRITE (1 cycle):
    - Not full: mem[wp] <= data_i, wp++, count++.
    - Full: no write, overrun_o <= 1.
    - Always goes to CLEAR.
  - CLEAR (1 cycle): deser_reset_o = 1; go to HOLD.
  - HOLD: wait until sync_out = 0, then go to IDLE. This blocks re-trigger on a lingering frame level.
- Latency: frame_i sampled high at edge k.
  - FSM enters WRITE at edge k+SYNC_STAGES.
  - Byte is visible on data_o/count_o after edge k+SYNC_STAGES+1.
  - deser_reset_o is high for the cycle after that edge.
- Pointers: DEPTH_LOG2 bits, natural wrap at DEPTH. count is DEPTH_LOG2+1 bits. full_o = (count == DEPTH), empty_o = (count == 0).
- Pop: rd_i with !empty_o advances rp and decrements count at the edge. rd_i while empty is ignored, with no state change.
- Simultaneous write and pop in one edge: count unchanged, both pointers advance. This is legal when full: the pop makes room, so the write succeeds and no overrun is flagged.
- overrun_o: a set and ovr_clr_i in the same cycle leaves it 1 (set wins).
- Reset mid-operation returns to IDLE immediately. If frame_i is still high after release, the zeroed synchroniser yields a fresh rise and the held byte is captured once.

Optional Feature:
UXA_PS2_RXQ_OVERWRITE_EN.
- Defined: a frame in WRITE while full (without simultaneous pop) overwrites the oldest entry. mem[wp] <= data_i, wp++ and rp++; count stays DEPTH; overrun_o <= 1.
- Undefined: the new byte is dropped and FIFO contents are untouched, as above.

Decomposition:
- Package uxa_ps2_pkg:
  - one-hot state constants S_IDLE, S_WRITE, S_CLEAR, S_HOLD;
  - default DATA_W and DEPTH_LOG2.
- Sub-module m_uxa_ps2_sync: SYNC_STAGES-deep synchroniser plus edge register, outputting sync level and rise pulse. Also reusable for the PS/2 clock line.
- FIFO storage stays inline: a simple register array with async read.

Test Plan:
1. Reset, then frame_i high with data_i=8'hA5 at edge k (SYNC_STAGES=2). Required: count_o=1 and data_o=8'hA5 after edge k+3, empty_o=0. deser_reset_o high exactly one cycle, k+3..k+4.
2. frame_i held high 20 cycles after one capture. Required: exactly one write and one deser_reset_o pulse. A second rise after frame_i drops for 3+ cycles captures again.
3. Push 16 frames 0x00..0x0F, then a 17th of 0x55. Required: full_o=1, count_o=16, overrun_o=1, data_o=0x00. With OVERWRITE_EN: data_o=0x01, and 0x55 is the last entry popped.
4. Full FIFO with rd_i asserted in the same cycle as WRITE. Required: count_o stays 16, overrun_o stays 0, pop order continues 0x01..0x0F then the new byte.
5. rd_i on empty FIFO for 5 cycles. Required: count_o=0, pointers unchanged, a subsequent push of 0x3C reads back 0x3C.
6. Assert sys_reset_i during the CLEAR state with frame_i high. Required: all outputs at reset values immediately. After release, one capture of the held data_i, count_o=1.
